parking_lane_arbiter: RTL and testbench
=======================================

PARKING_LANE_ARBITER -- requirements
Module: parking_lane_arbiter

Interface
REQ-001 Parameter CAPACITY, default 8, sets the maximum vehicles inside; the legal range is 1..15.
REQ-002 Parameter TIMEOUT, default 16, sets the cycles allowed in GRANT before ctrl_open_gate must rise; the legal range is 2..255.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 req  input  2  per-lane vehicle-present requests; bit0 is lane 0 and bit1 is lane 1.
REQ-006 exit_evt  input  1  one-cycle pulse when a vehicle leaves through the exit.
REQ-007 ctrl_open_gate  input  1  open_gate from the shared gate controller.
REQ-008 ctrl_close_gate  input  1  close_gate from the shared gate controller.
REQ-009 ctrl_alarm_blocked  input  1  alarm_blocked from the shared gate controller.
REQ-010 grant  output  2  one-hot lane grant; all zeros when no lane is granted.
REQ-011 sensor_vehicule_out  output  1  drives the controller's sensor_vehicule; equals OR of grant.
REQ-012 occupancy  output  4  current vehicle count.
REQ-013 full  output  1  high when occupancy equals CAPACITY.
REQ-014 timeout_err  output  1  one-cycle pulse when a grant expires.
REQ-015 blocked  output  1  high while the FSM is in the BLOCKED state.

Function
REQ-016 The FSM shall have exactly four states: IDLE, GRANT, PASS and BLOCKED.
REQ-017 IDLE shall move to GRANT on the next edge when req is nonzero and full is low; grant shall be registered and valid in the first GRANT cycle.
REQ-018 Round-robin selection: if both req bits are set, grant the lane not served last; if one bit is set, grant that lane; after reset, lane 0 wins.
REQ-019 grant shall stay stable throughout GRANT and PASS, even if the granted req bit drops.
REQ-020 GRANT shall move to PASS on ctrl_open_gate=1, and shall move to BLOCKED on ctrl_alarm_blocked=1; if both are high in the same cycle, BLOCKED wins.
REQ-021 PASS shall move to IDLE on ctrl_close_gate=1; on that transition occupancy shall increment, grant shall clear, and the last-served pointer shall update to the granted lane.
REQ-022 BLOCKED shall hold grant at zero and sensor_vehicule_out at 0, and shall be left only via rst.
REQ-023 While full is high, no grant shall be issued, and req shall be ignored but not lost (it is re-evaluated every IDLE cycle).
REQ-024 exit_evt shall decrement occupancy in any state; exit_evt at occupancy 0 shall be ignored.
REQ-025 Increment and exit_evt in the same cycle shall leave occupancy unchanged.
REQ-026 Increment at occupancy==CAPACITY shall be impossible by construction (entry to GRANT is gated by full), and occupancy shall never exceed CAPACITY.
REQ-027 full shall be combinational from registered occupancy.

Reset
REQ-028 Asserting rst shall immediately force: state=IDLE, grant=0, sensor_vehicule_out=0, occupancy=0, full=0, timeout_err=0, blocked=0, last-served pointer=lane 1, timeout counter=0.
REQ-029 Reset asserted during GRANT or PASS shall abort the transaction with no occupancy change.

Configuration
REQ-030 Macro ARB_TIMEOUT_EN shall compile the grant-timeout feature in or out.
REQ-031 With ARB_TIMEOUT_EN defined: an 8-bit counter shall clear on entering GRANT; if TIMEOUT cycles elapse in GRANT without ctrl_open_gate, the FSM shall return to IDLE, clear grant, pulse timeout_err for one cycle, and set the last-served pointer to the timed-out lane.
REQ-032 Without ARB_TIMEOUT_EN: GRANT shall wait indefinitely, no counter shall exist, and timeout_err shall be tied to 0.

Verification
REQ-033 Single entry: req=01, then ctrl_open_gate, then ctrl_close_gate -> grant=01 one cycle after req; occupancy 0->1 on the close edge; grant=00.
REQ-034 Contention: req=11 held for two full transactions -> first grant=01, second grant=10.
REQ-035 Full: CAPACITY=2 with two completed entries, then req=01 -> full=1 and grant stays 00; exit_evt -> occupancy=1, full=0, grant=01 next cycle.
REQ-036 Simultaneous: exit_evt coincident with the ctrl_close_gate edge at occupancy 3 -> occupancy stays 3.
REQ-037 Blocked: ctrl_alarm_blocked=1 in GRANT -> blocked=1, grant=00, req ignored until rst; rst -> all outputs 0.
REQ-038 Timeout (ARB_TIMEOUT_EN, TIMEOUT=4): req=11 with no open -> grant=01 for 4 cycles, timeout_err pulse, then grant=10.

Source files
------------

// File: rtl/parking_lane_arbiter.sv
`default_nettype none
// =============================================================================
// Module  : parking_lane_arbiter
// Two-lane round-robin entry arbiter for a shared gate controller, with
// occupancy tracking. Define ARB_TIMEOUT_EN to build in the grant timeout.
// Revision: 1.0
// =============================================================================
module parking_lane_arbiter #(
   parameter int CAPACITY = 8,
   parameter int TIMEOUT  = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       exit_evt,
   input  logic       ctrl_open_gate,
   input  logic       ctrl_close_gate,
   input  logic       ctrl_alarm_blocked,
   output logic [1:0] grant,
   output logic       sensor_vehicule_out,
   output logic [3:0] occupancy,
   output logic       full,
   output logic       timeout_err,
   output logic       blocked
);

   if (CAPACITY < 1 || CAPACITY > 15 || TIMEOUT < 2 || TIMEOUT > 255) begin : g_param_check
      $error("parking_lane_arbiter: CAPACITY or TIMEOUT out of range");
   end

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_GRANT   = 2'd1,
      S_PASS    = 2'd2,
      S_BLOCKED = 2'd3
   } state_t;

   state_t     state_q;
   logic [1:0] grant_q;
   logic [1:0] grant_d;
   logic       sensor_q;
   logic       blocked_q;
   logic       last_q;
   logic [3:0] occupancy_q;
   logic [3:0] occupancy_d;
   logic       inc;
   logic       dec;

`ifdef ARB_TIMEOUT_EN
   logic [7:0] tmo_cnt_q;
   logic       timeout_err_q;
`endif

   // Both lanes asking: serve the one not served last (last_q=1 means lane 1).
   always_comb begin
      grant_d = 2'b00;
      case (req)
         2'b01:   grant_d = 2'b01;
         2'b10:   grant_d = 2'b10;
         2'b11:   grant_d = last_q ? 2'b01 : 2'b10;
         default: grant_d = 2'b00;
      endcase
   end

   always_comb begin
      inc         = (state_q == S_PASS) && ctrl_close_gate;
      dec         = exit_evt && (occupancy_q != 4'd0);
      occupancy_d = occupancy_q;
      if (inc && !dec) begin
         occupancy_d = occupancy_q + 4'd1;
      end else if (dec && !inc) begin
         occupancy_d = occupancy_q - 4'd1;
      end
   end

   assign full = (occupancy_q == 4'(CAPACITY));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         grant_q       <= 2'b00;
         sensor_q      <= 1'b0;
         blocked_q     <= 1'b0;
         last_q        <= 1'b1;
         occupancy_q   <= 4'd0;
`ifdef ARB_TIMEOUT_EN
         tmo_cnt_q     <= 8'd0;
         timeout_err_q <= 1'b0;
`endif
      end else begin
         occupancy_q <= occupancy_d;
`ifdef ARB_TIMEOUT_EN
         timeout_err_q <= 1'b0;
`endif
         case (state_q)
            S_IDLE: begin
               if (req != 2'b00 && !full) begin
                  state_q  <= S_GRANT;
                  grant_q  <= grant_d;
                  sensor_q <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                  tmo_cnt_q <= 8'd0;
`endif
               end
            end
            S_GRANT: begin
               if (ctrl_alarm_blocked) begin
                  state_q   <= S_BLOCKED;
                  grant_q   <= 2'b00;
                  sensor_q  <= 1'b0;
                  blocked_q <= 1'b1;
               end else if (ctrl_open_gate) begin
                  state_q <= S_PASS;
               end
`ifdef ARB_TIMEOUT_EN
               else if (tmo_cnt_q == 8'(TIMEOUT - 1)) begin
                  state_q       <= S_IDLE;
                  grant_q       <= 2'b00;
                  sensor_q      <= 1'b0;
                  timeout_err_q <= 1'b1;
                  last_q        <= grant_q[1];
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + 8'd1;
               end
`endif
            end
            S_PASS: begin
               if (ctrl_close_gate) begin
                  state_q  <= S_IDLE;
                  grant_q  <= 2'b00;
                  sensor_q <= 1'b0;
                  last_q   <= grant_q[1];
               end
            end
            S_BLOCKED: begin
               grant_q  <= 2'b00;
               sensor_q <= 1'b0;
            end
            default: begin
               state_q  <= S_IDLE;
               grant_q  <= 2'b00;
               sensor_q <= 1'b0;
            end
         endcase
      end
   end

   assign grant               = grant_q;
   assign sensor_vehicule_out = sensor_q;
   assign occupancy           = occupancy_q;
   assign blocked             = blocked_q;

`ifdef ARB_TIMEOUT_EN
   assign timeout_err = timeout_err_q;
`else
   assign timeout_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_parking_lane_arbiter.sv
`default_nettype none
// =============================================================================
// Module  : tb_parking_lane_arbiter
// Directed and random checks of parking_lane_arbiter against a lane/phase model.
// Revision: 1.0
// =============================================================================
module tb_parking_lane_arbiter;

   localparam int CAP = 4;
   localparam int TMO = 4;
`ifdef ARB_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] req;
   logic       exit_evt;
   logic       ctrl_open_gate;
   logic       ctrl_close_gate;
   logic       ctrl_alarm_blocked;
   logic [1:0] grant;
   logic       sensor_vehicule_out;
   logic [3:0] occupancy;
   logic       full;
   logic       timeout_err;
   logic       blocked;

   parking_lane_arbiter #(
      .CAPACITY (CAP),
      .TIMEOUT  (TMO)
   ) dut (
      .clk                 (clk),
      .rst                 (rst),
      .req                 (req),
      .exit_evt            (exit_evt),
      .ctrl_open_gate      (ctrl_open_gate),
      .ctrl_close_gate     (ctrl_close_gate),
      .ctrl_alarm_blocked  (ctrl_alarm_blocked),
      .grant               (grant),
      .sensor_vehicule_out (sensor_vehicule_out),
      .occupancy           (occupancy),
      .full                (full),
      .timeout_err         (timeout_err),
      .blocked             (blocked)
   );

   always #5 clk = ~clk;

   int n_err = 0;
   int n_chk = 0;

   // Model: which lane holds the grant (-1 none), whether the gate opened,
   // cars inside, lane served last, cycles waited in grant.
   int m_lane;
   bit m_pass;
   bit m_blk;
   bit m_tmo;
   int m_occ;
   int m_last;
   int m_wait;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_lane = -1;
      m_pass = 1'b0;
      m_blk  = 1'b0;
      m_tmo  = 1'b0;
      m_occ  = 0;
      m_last = 1;
      m_wait = 0;
   endtask

   task automatic model_edge();
      int lane_n;
      int last_n;
      int wait_n;
      bit pass_n;
      bit blk_n;
      bit tmo_n;
      int inc;
      int dec;
      lane_n = m_lane;
      last_n = m_last;
      wait_n = m_wait;
      pass_n = m_pass;
      blk_n  = m_blk;
      tmo_n  = 1'b0;
      inc    = 0;
      if (m_blk) begin
         lane_n = -1;
      end else if (m_lane < 0) begin
         if (req != 2'b00 && m_occ < CAP) begin
            if (req == 2'b11) lane_n = 1 - m_last;
            else lane_n = req[1] ? 1 : 0;
            pass_n = 1'b0;
            wait_n = 0;
         end
      end else if (!m_pass) begin
         if (ctrl_alarm_blocked) begin
            blk_n  = 1'b1;
            lane_n = -1;
         end else if (ctrl_open_gate) begin
            pass_n = 1'b1;
         end else if (TMO_EN && m_wait == TMO - 1) begin
            tmo_n  = 1'b1;
            last_n = m_lane;
            lane_n = -1;
         end else begin
            wait_n = m_wait + 1;
         end
      end else if (ctrl_close_gate) begin
         inc    = 1;
         last_n = m_lane;
         lane_n = -1;
         pass_n = 1'b0;
      end
      dec    = (exit_evt && m_occ > 0) ? 1 : 0;
      m_occ  = m_occ + inc - dec;
      m_lane = lane_n;
      m_last = last_n;
      m_wait = wait_n;
      m_pass = pass_n;
      m_blk  = blk_n;
      m_tmo  = tmo_n;
   endtask

   task automatic check_all(input string tag);
      logic [7:0] g;
      g = (m_lane < 0) ? 8'd0 : 8'(1 << m_lane);
      chk({tag, ".grant"},   8'(grant), g);
      chk({tag, ".sensor"},  8'(sensor_vehicule_out), (m_lane < 0) ? 8'd0 : 8'd1);
      chk({tag, ".occ"},     8'(occupancy), 8'(m_occ));
      chk({tag, ".full"},    8'(full), (m_occ == CAP) ? 8'd1 : 8'd0);
      chk({tag, ".tmo"},     8'(timeout_err), 8'(m_tmo));
      chk({tag, ".blocked"}, 8'(blocked), 8'(m_blk));
   endtask

   task automatic set_in(input logic [1:0] r, input logic ex, input logic op,
                         input logic cl, input logic al);
      req                = r;
      exit_evt           = ex;
      ctrl_open_gate     = op;
      ctrl_close_gate    = cl;
      ctrl_alarm_blocked = al;
   endtask

   task automatic cyc(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   task automatic async_reset(input string tag);
      rst = 1'b1;
      #1;
      model_reset();
      check_all(tag);
      set_in(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic txn(input logic [1:0] r, input logic ex_on_close);
      set_in(r, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc("txn_req");
      set_in(2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc("txn_open");
      set_in(2'b00, ex_on_close, 1'b0, 1'b1, 1'b0);
      cyc("txn_close");
      set_in(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      set_in(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      #2;
      model_reset();
      check_all("por");
      @(negedge clk);
      rst = 1'b0;

      // Single entry
      set_in(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc("single_req");
      chk("single.grant", 8'(grant), 8'h01);
      set_in(2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc("single_open");
      set_in(2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc("single_close");
      chk("single.occ", 8'(occupancy), 8'd1);
      chk("single.grant0", 8'(grant), 8'h00);

      // Contention from reset: lane 0 first, then lane 1
      async_reset("rst_a");
      set_in(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc("cont_req1");
      chk("cont.first", 8'(grant), 8'h01);
      set_in(2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc("cont_open1");
      set_in(2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc("cont_close1");
      set_in(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc("cont_req2");
      chk("cont.second", 8'(grant), 8'h02);
      set_in(2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc("cont_open2");
      set_in(2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc("cont_close2");
      chk("cont.occ", 8'(occupancy), 8'd2);

      // Fill up, with a coincident exit on one close edge
      txn(2'b01, 1'b0);
      chk("fill.occ3", 8'(occupancy), 8'd3);
      txn(2'b01, 1'b1);
      chk("simul.occ", 8'(occupancy), 8'd3);
      txn(2'b10, 1'b0);
      chk("full.flag", 8'(full), 8'd1);
      set_in(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cyc("full_hold");
         chk("full.nogrant", 8'(grant), 8'h00);
      end
      set_in(2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc("full_exit");
      chk("full.exit_occ", 8'(occupancy), 8'd3);
      chk("full.exit_flag", 8'(full), 8'd0);
      set_in(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc("full_regrant");
      chk("full.regrant", 8'(grant), 8'h01);
      set_in(2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc("full_open");
      set_in(2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc("full_close");
      set_in(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

      // Alarm and open together in grant: blocked wins and is sticky
      async_reset("rst_b");
      set_in(2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc("blk_req");
      set_in(2'b10, 1'b0, 1'b1, 1'b0, 1'b1);
      cyc("blk_alarm");
      chk("blk.flag", 8'(blocked), 8'd1);
      chk("blk.grant", 8'(grant), 8'h00);
      for (int i = 0; i < 4; i++) begin
         set_in(2'b11, i == 2, i[0], ~i[0], 1'b0);
         cyc("blk_hold");
         chk("blk.hold", {6'd0, grant}, 8'h00);
      end
      async_reset("rst_c");
      chk("rst.blocked", 8'(blocked), 8'd0);
      chk("rst.sensor", 8'(sensor_vehicule_out), 8'd0);

      // Reset in the middle of a pass aborts it
      txn(2'b01, 1'b0);
      set_in(2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc("abort_req");
      set_in(2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc("abort_open");
      async_reset("rst_abort");

      // Grant without any open: times out only when the feature is built in
      set_in(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < TMO; i++) begin
         cyc("tmo_wait");
         chk("tmo.grant_wait", 8'(grant), 8'h01);
      end
      cyc("tmo_expire");
`ifdef ARB_TIMEOUT_EN
      chk("tmo.pulse", 8'(timeout_err), 8'd1);
      chk("tmo.cleared", 8'(grant), 8'h00);
`endif
      cyc("tmo_next");
`ifdef ARB_TIMEOUT_EN
      chk("tmo.other_lane", 8'(grant), 8'h02);
      chk("tmo.pulse_end", 8'(timeout_err), 8'd0);
`else
      chk("tmo.still_waiting", 8'(grant), 8'h01);
`endif
      async_reset("rst_d");

      // Random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) async_reset("rnd_rst");
         set_in(2'($urandom_range(0, 3)),
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 99) == 0);
         cyc("rnd");
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
